inst_mem_resp: RTL and testbench

- Instruction-memory responder serving the core's fetch side: accepts a fetch address and returns the 32-bit instruction word after a fixed latency.
- Holds the program image in an internal word array, loaded through a dedicated load port by the bench or boot logic.
- Uses a valid/ready request channel and a valid/ready response channel. Exactly one request is outstanding at a time; back-to-back fetches are allowed when a response fires in the same cycle.

---
 rtl/inst_mem_resp.sv | 124 ++++++++++++
 tb/tb_inst_mem_resp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: fixed-latency instruction memory responder
// with valid/ready request and response channels.
module inst_mem_resp #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY   = 1,
  localparam int unsigned IW       = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic [63:0]   ReqAddr,
  output logic          RespValid,
  input  logic          RespReady,
  output logic [31:0]   RespInst,
  output logic          RespErr,
  input  logic          LoadEnable,
  input  logic [IW-1:0] LoadIndex,
  input  logic [31:0]   LoadData
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic [63:0] offset;
  logic        bad_addr;
  logic [31:0] rd_word;
  logic        req_ready;
  logic        accept;

  // decode the fetch address and read the array in the accept cycle
  always_comb begin
    offset   = ReqAddr - BASE_ADDR;
    bad_addr = (|ReqAddr[1:0]) | (|offset[1:0])
             | (ReqAddr < BASE_ADDR)
             | (|offset[63:IW+2]);
    rd_word  = mem_q[offset[IW+1:2]];
  end

  // request handshake: idle, or retiring a response this cycle
  always_comb begin
    req_ready = 1'b0;
    if (!Rst) begin
      req_ready = (state_q == IDLE)
                | ((state_q == RESP) & RespReady);
    end
    accept = ReqValid & req_ready;
  end

  // next-state, latency countdown and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: ;
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (RespReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      inst_d = bad_addr ? NOP : rd_word;
      err_d  = bad_addr;
      if (LATENCY == 1) begin
        state_d = RESP;
        cnt_d   = 3'd0;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
    end
  end

  // control and response registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // program image; reads above see the pre-write word
  always_ff @(posedge Clk) begin
    if (LoadEnable) begin
      mem_q[LoadIndex] <= LoadData;
    end
  end

  assign ReqReady  = req_ready;
  assign RespValid = (state_q == RESP);
  assign RespInst  = inst_q;
  assign RespErr   = err_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed tests for inst_mem_resp
// with one LATENCY=1 and one LATENCY=3 instance.
module tb_inst_mem_resp;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_req_valid, a_req_ready;
  logic [63:0] a_req_addr;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_inst;
  logic        a_load_en;
  logic [11:0] a_load_idx;
  logic [31:0] a_load_data;

  logic        b_req_valid, b_req_ready;
  logic [63:0] b_req_addr;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_inst;
  logic        b_load_en;
  logic [11:0] b_load_idx;
  logic [31:0] b_load_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] prog [4];

  inst_mem_resp #(.LATENCY(1)) u_a (
    .Clk(clk), .Rst(rst),
    .ReqValid(a_req_valid), .ReqReady(a_req_ready),
    .ReqAddr(a_req_addr),
    .RespValid(a_resp_valid), .RespReady(a_resp_ready),
    .RespInst(a_resp_inst), .RespErr(a_resp_err),
    .LoadEnable(a_load_en), .LoadIndex(a_load_idx),
    .LoadData(a_load_data)
  );

  inst_mem_resp #(.LATENCY(3)) u_b (
    .Clk(clk), .Rst(rst),
    .ReqValid(b_req_valid), .ReqReady(b_req_ready),
    .ReqAddr(b_req_addr),
    .RespValid(b_resp_valid), .RespReady(b_resp_ready),
    .RespInst(b_resp_inst), .RespErr(b_resp_err),
    .LoadEnable(b_load_en), .LoadIndex(b_load_idx),
    .LoadData(b_load_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_both(input logic [11:0] idx,
                           input logic [31:0] data);
    a_load_en = 1'b1; a_load_idx = idx; a_load_data = data;
    b_load_en = 1'b1; b_load_idx = idx; b_load_data = data;
    tick();
    a_load_en = 1'b0;
    b_load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready got %b want 0", a_req_ready); end
    n_tests++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got %b want 0", a_resp_valid); end
    n_tests++; if (a_resp_inst !== 32'd0) begin n_fail++; $display("FAIL rst_a_inst got %h want 0", a_resp_inst); end
    n_tests++; if (a_resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_a_err got %b want 0", a_resp_err); end
    n_tests++; if (b_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready got %b want 0", b_req_ready); end
    n_tests++; if (b_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid got %b want 0", b_resp_valid); end
    rst = 1'b0;
    #1;
    n_tests++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_a_ready got %b want 1", a_req_ready); end
    n_tests++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_b_ready got %b want 1", b_req_ready); end
  endtask

  task automatic test_back_to_back();
    a_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_req_valid = 1'b1;
      a_req_addr  = BASE + 64'(4 * i);
      #1;
      n_tests++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, a_req_ready); end
      tick();
      n_tests++; if (a_resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", i, a_resp_valid); end
      n_tests++; if (a_resp_inst !== prog[i]) begin n_fail++; $display("FAIL b2b_inst[%0d] got %h want %h", i, a_resp_inst, prog[i]); end
      n_tests++; if (a_resp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err[%0d] got %b want 0", i, a_resp_err); end
    end
    a_req_valid = 1'b0;
    tick();
    n_tests++; if (a_resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", a_resp_valid); end
  endtask

  task automatic test_latency();
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1;
    b_req_addr   = BASE + 64'h4;
    tick();
    b_req_valid = 1'b0;
    b_req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 1; i <= 2; i++) begin
      n_tests++; if (b_resp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid[%0d] got %b want 0", i, b_resp_valid); end
      n_tests++; if (b_req_ready !== 1'b0) begin n_fail++; $display("FAIL lat_ready[%0d] got %b want 0", i, b_req_ready); end
      tick();
    end
    n_tests++; if (b_resp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid[3] got %b want 1", b_resp_valid); end
    n_tests++; if (b_resp_inst !== 32'h0010_0113) begin n_fail++; $display("FAIL lat_inst got %h want 00100113", b_resp_inst); end
    n_tests++; if (b_resp_err !== 1'b0) begin n_fail++; $display("FAIL lat_err got %b want 0", b_resp_err); end
    tick();
    n_tests++; if (b_resp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_retire got %b want 0", b_resp_valid); end
  endtask

  task automatic test_stall();
    a_resp_ready = 1'b0;
    a_req_valid  = 1'b1;
    a_req_addr   = BASE + 64'h8;
    tick();
    a_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_req_addr = BASE + 64'(4 * i);
      #1;
      n_tests++; if (a_resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", i, a_resp_valid); end
      n_tests++; if (a_resp_inst !== 32'h0020_81B3) begin n_fail++; $display("FAIL stall_inst[%0d] got %h want 002081b3", i, a_resp_inst); end
      n_tests++; if (a_resp_err !== 1'b0) begin n_fail++; $display("FAIL stall_err[%0d] got %b want 0", i, a_resp_err); end
      n_tests++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", i, a_req_ready); end
      tick();
    end
    a_resp_ready = 1'b1;
    a_req_valid  = 1'b1;
    a_req_addr   = BASE + 64'hC;
    #1;
    n_tests++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rel_ready got %b want 1", a_req_ready); end
    tick();
    a_req_valid = 1'b0;
    n_tests++; if (a_resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_next_valid got %b want 1", a_resp_valid); end
    n_tests++; if (a_resp_inst !== NOP) begin n_fail++; $display("FAIL stall_next_inst got %h want 00000013", a_resp_inst); end
    tick();
  endtask

  task automatic test_errors();
    logic [63:0] addrs [4];
    logic        errs  [4];
    logic [31:0] insts [4];
    addrs[0] = BASE + 64'h2;          errs[0] = 1'b1; insts[0] = NOP;
    addrs[1] = BASE - 64'h4;          errs[1] = 1'b1; insts[1] = NOP;
    addrs[2] = BASE + 64'(4096 * 4);  errs[2] = 1'b1; insts[2] = NOP;
    addrs[3] = BASE + 64'(4095 * 4);  errs[3] = 1'b0; insts[3] = 32'hCAFE_F00D;
    a_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_req_valid = 1'b1;
      a_req_addr  = addrs[i];
      tick();
      n_tests++; if (a_resp_valid !== 1'b1) begin n_fail++; $display("FAIL err_valid[%0d] got %b want 1", i, a_resp_valid); end
      n_tests++; if (a_resp_err !== errs[i]) begin n_fail++; $display("FAIL err_flag[%0d] got %b want %b", i, a_resp_err, errs[i]); end
      n_tests++; if (a_resp_inst !== insts[i]) begin n_fail++; $display("FAIL err_inst[%0d] got %h want %h", i, a_resp_inst, insts[i]); end
    end
    a_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_collision();
    a_resp_ready = 1'b1;
    a_req_valid  = 1'b1;
    a_req_addr   = BASE + 64'h8;
    a_load_en    = 1'b1;
    a_load_idx   = 12'd2;
    a_load_data  = 32'hDEAD_BEEF;
    tick();
    a_load_en = 1'b0;
    n_tests++; if (a_resp_inst !== 32'h0020_81B3) begin n_fail++; $display("FAIL rbw_old got %h want 002081b3", a_resp_inst); end
    tick();
    a_req_valid = 1'b0;
    n_tests++; if (a_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rbw_new_valid got %b want 1", a_resp_valid); end
    n_tests++; if (a_resp_inst !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rbw_new got %h want deadbeef", a_resp_inst); end
    tick();
  endtask

  task automatic test_load_pending();
    a_resp_ready = 1'b0;
    a_req_valid  = 1'b1;
    a_req_addr   = BASE + 64'h4;
    tick();
    a_req_valid = 1'b0;
    a_load_en   = 1'b1;
    a_load_idx  = 12'd1;
    a_load_data = 32'h1111_1111;
    tick();
    a_load_en = 1'b0;
    n_tests++; if (a_resp_inst !== 32'h0010_0113) begin n_fail++; $display("FAIL pend_keep got %h want 00100113", a_resp_inst); end
    a_resp_ready = 1'b1;
    a_req_valid  = 1'b1;
    tick();
    a_req_valid = 1'b0;
    n_tests++; if (a_resp_inst !== 32'h1111_1111) begin n_fail++; $display("FAIL pend_new got %h want 11111111", a_resp_inst); end
    tick();
  endtask

  task automatic test_reset_mid();
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1;
    b_req_addr   = BASE;
    tick();
    b_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", b_req_ready); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (b_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid[%0d] got %b want 0", i, b_resp_valid); end
      tick();
    end
    b_req_valid = 1'b1;
    b_req_addr  = BASE + 64'h8;
    tick();
    b_req_valid = 1'b0;
    tick();
    tick();
    n_tests++; if (b_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_fetch_valid got %b want 1", b_resp_valid); end
    n_tests++; if (b_resp_inst !== 32'h0020_81B3) begin n_fail++; $display("FAIL rmid_array got %h want 002081b3", b_resp_inst); end
    tick();
  endtask

  initial begin
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b0;
    a_load_en = 1'b0; a_load_idx = '0; a_load_data = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b0;
    b_load_en = 1'b0; b_load_idx = '0; b_load_data = '0;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      load_both(12'(i), prog[i]);
    end
    load_both(12'd4095, 32'hCAFE_F00D);
    test_back_to_back();
    test_latency();
    test_stall();
    test_errors();
    test_load_collision();
    test_load_pending();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
